// File: rtl/hazard_pkg.sv
// -----------------------------------------------------------------------------
// hazard_pkg
// Shared definitions for the hazard/forwarding unit that sits beside decode.
//   - FWD_* : operand source select encodings driven on fwd_rsN_sel.
//   - slot_t: one in-flight destination record {v, rd, ld} for EX/MEM/WB.
//   - SLOT_BUBBLE: an empty slot (no register write in flight).
// -----------------------------------------------------------------------------
package hazard_pkg;

  localparam logic [1:0] FWD_REGFILE = 2'd0;
  localparam logic [1:0] FWD_EX      = 2'd1;
  localparam logic [1:0] FWD_MEM     = 2'd2;
  localparam logic [1:0] FWD_WB      = 2'd3;

  typedef struct packed {
    logic       v;   // slot writes a nonzero rd
    logic [4:0] rd;  // destination register index
    logic       ld;  // producing instruction is a load
  } slot_t;

  localparam slot_t SLOT_BUBBLE = '{v: 1'b0, rd: 5'd0, ld: 1'b0};

endpackage

// File: rtl/forward_mux_unit.sv
// -----------------------------------------------------------------------------
// forward_mux_unit
// Priority match and operand mux for one decode source operand.
// Priority is EX > MEM > WB > register file; x0 or an unused source always
// takes the register-file value.
// Ports:
//   rs, rs_used            : source index and "instruction reads it"
//   ex_v/ex_rd, mem_v/mem_rd, wb_v/wb_rd : in-flight destination records
//   rf_data, ex_result, mem_result, wb_data : candidate operand values
//   sel                    : chosen source (FWD_* encoding)
//   data                   : resolved operand value
//   ex_hit                 : the EX slot matched (used for load-use detection)
// -----------------------------------------------------------------------------
module forward_mux_unit
  import hazard_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [4:0]            rs,
  input  logic                  rs_used,
  input  logic                  ex_v,
  input  logic [4:0]            ex_rd,
  input  logic                  mem_v,
  input  logic [4:0]            mem_rd,
  input  logic                  wb_v,
  input  logic [4:0]            wb_rd,
  input  logic [DATA_WIDTH-1:0] rf_data,
  input  logic [DATA_WIDTH-1:0] ex_result,
  input  logic [DATA_WIDTH-1:0] mem_result,
  input  logic [DATA_WIDTH-1:0] wb_data,
  output logic [1:0]            sel,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  ex_hit
);

  logic       rs_live_s;
  logic       ex_hit_s;
  logic       mem_hit_s;
  logic       wb_hit_s;
  logic [1:0] sel_s;

  // Per-slot match: a slot only forwards to a live, nonzero source.
  always_comb begin
    rs_live_s = rs_used && (rs != 5'd0);
    ex_hit_s  = rs_live_s && ex_v  && (ex_rd  == rs);
    mem_hit_s = rs_live_s && mem_v && (mem_rd == rs);
    wb_hit_s  = rs_live_s && wb_v  && (wb_rd  == rs);
  end

  // Youngest producer wins.
  always_comb begin
    sel_s = FWD_REGFILE;
    if (ex_hit_s) begin
      sel_s = FWD_EX;
    end else if (mem_hit_s) begin
      sel_s = FWD_MEM;
    end else if (wb_hit_s) begin
      sel_s = FWD_WB;
    end else begin
      sel_s = FWD_REGFILE;
    end
  end

  // Operand data mux for the chosen source.
  always_comb begin
    data = rf_data;
    case (sel_s)
      FWD_EX:  data = ex_result;
      FWD_MEM: data = mem_result;
      FWD_WB:  data = wb_data;
      default: data = rf_data;
    endcase
  end

  assign sel    = sel_s;
  assign ex_hit = ex_hit_s;

endmodule

// File: rtl/hazard_forward_unit.sv
// -----------------------------------------------------------------------------
// hazard_forward_unit
// Tracks the destinations of the instructions in EX, MEM and WB, forwards
// operands back into decode, and produces stall/flush for IF/ID and ID/EX.
// Selects, data, stall and flush are combinational from the slot registers
// and the current inputs.
//
// Optional build macro: HAZARD_STATS_EN adds saturating 32-bit stall_count
// (load-use stall cycles) and flush_count (flush cycles) outputs.
//
// Ports:
//   clock, reset (async, active-low)
//   id_*               : decode-stage instruction fields and regfile data
//   ex_result, mem_result, wb_data : in-flight results for forwarding
//   ex_branch_taken    : EX redirects the PC
//   mem_stall          : data memory not ready, whole pipeline frozen
//   fwd_rsN_sel/_data  : resolved operand source and value
//   stall, flush       : pipeline control back to IF/ID and ID/EX
// -----------------------------------------------------------------------------
module hazard_forward_unit
  import hazard_pkg::*;
#(
  parameter int CORE       = 0,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  id_valid,
  input  logic [4:0]            id_rs1,
  input  logic [4:0]            id_rs2,
  input  logic                  id_rs1_used,
  input  logic                  id_rs2_used,
  input  logic [4:0]            id_rd,
  input  logic                  id_reg_write,
  input  logic                  id_is_load,
  input  logic [DATA_WIDTH-1:0] id_rs1_data,
  input  logic [DATA_WIDTH-1:0] id_rs2_data,
  input  logic [DATA_WIDTH-1:0] ex_result,
  input  logic [DATA_WIDTH-1:0] mem_result,
  input  logic [DATA_WIDTH-1:0] wb_data,
  input  logic                  ex_branch_taken,
  input  logic                  mem_stall,
  output logic [1:0]            fwd_rs1_sel,
  output logic [1:0]            fwd_rs2_sel,
  output logic [DATA_WIDTH-1:0] fwd_rs1_data,
  output logic [DATA_WIDTH-1:0] fwd_rs2_data,
  output logic                  stall,
  output logic                  flush
`ifdef HAZARD_STATS_EN
  ,
  output logic [31:0]           stall_count,
  output logic [31:0]           flush_count
`endif
);

  // CORE only tags the instance; a negative index elaborates nothing extra.
  if (CORE < 0) begin : g_core_tag_unused
  end

  slot_t ex_slot_r;
  slot_t mem_slot_r;
  slot_t wb_slot_r;
  slot_t ex_next_s;

  logic rs1_ex_hit_s;
  logic rs2_ex_hit_s;
  logic load_use_s;
  logic load_use_stall_s;
  logic stall_s;
  logic flush_s;

  forward_mux_unit #(.DATA_WIDTH(DATA_WIDTH)) u_fwd_rs1 (
    .rs         (id_rs1),
    .rs_used    (id_rs1_used),
    .ex_v       (ex_slot_r.v),
    .ex_rd      (ex_slot_r.rd),
    .mem_v      (mem_slot_r.v),
    .mem_rd     (mem_slot_r.rd),
    .wb_v       (wb_slot_r.v),
    .wb_rd      (wb_slot_r.rd),
    .rf_data    (id_rs1_data),
    .ex_result  (ex_result),
    .mem_result (mem_result),
    .wb_data    (wb_data),
    .sel        (fwd_rs1_sel),
    .data       (fwd_rs1_data),
    .ex_hit     (rs1_ex_hit_s)
  );

  forward_mux_unit #(.DATA_WIDTH(DATA_WIDTH)) u_fwd_rs2 (
    .rs         (id_rs2),
    .rs_used    (id_rs2_used),
    .ex_v       (ex_slot_r.v),
    .ex_rd      (ex_slot_r.rd),
    .mem_v      (mem_slot_r.v),
    .mem_rd     (mem_slot_r.rd),
    .wb_v       (wb_slot_r.v),
    .wb_rd      (wb_slot_r.rd),
    .rf_data    (id_rs2_data),
    .ex_result  (ex_result),
    .mem_result (mem_result),
    .wb_data    (wb_data),
    .sel        (fwd_rs2_sel),
    .data       (fwd_rs2_data),
    .ex_hit     (rs2_ex_hit_s)
  );

  // Load-use and pipeline control. A load in EX has no data yet, so an EX
  // match on a load must stall even if MEM/WB also hold that register.
  // A taken branch kills the decode instruction, so it takes precedence
  // over the load-use stall; during a memory freeze the branch waits.
  always_comb begin
    load_use_s       = (rs1_ex_hit_s | rs2_ex_hit_s) & ex_slot_r.ld;
    load_use_stall_s = load_use_s & id_valid & ~ex_branch_taken;
    stall_s          = mem_stall | load_use_stall_s;
    flush_s          = ex_branch_taken & ~mem_stall;
  end

  // Record entering EX: a bubble when decode is held or killed.
  always_comb begin
    ex_next_s = SLOT_BUBBLE;
    if (stall_s || flush_s) begin
      ex_next_s = SLOT_BUBBLE;
    end else begin
      ex_next_s.v  = id_valid & id_reg_write & (id_rd != 5'd0);
      ex_next_s.rd = id_rd;
      ex_next_s.ld = id_is_load;
    end
  end

  // Slot pipeline EX -> MEM -> WB; frozen while data memory is not ready.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ex_slot_r  <= SLOT_BUBBLE;
      mem_slot_r <= SLOT_BUBBLE;
      wb_slot_r  <= SLOT_BUBBLE;
    end else if (!mem_stall) begin
      wb_slot_r  <= mem_slot_r;
      mem_slot_r <= ex_slot_r;
      ex_slot_r  <= ex_next_s;
    end
  end

  assign stall = stall_s;
  assign flush = flush_s;

`ifdef HAZARD_STATS_EN
  logic [31:0] stall_count_r;
  logic [31:0] flush_count_r;

  // Saturating event counters for load-use stalls and flushes.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stall_count_r <= 32'd0;
      flush_count_r <= 32'd0;
    end else begin
      if (load_use_stall_s && (stall_count_r != 32'hFFFF_FFFF)) begin
        stall_count_r <= stall_count_r + 32'd1;
      end
      if (flush_s && (flush_count_r != 32'hFFFF_FFFF)) begin
        flush_count_r <= flush_count_r + 32'd1;
      end
    end
  end

  assign stall_count = stall_count_r;
  assign flush_count = flush_count_r;
`endif

endmodule

// File: tb/tb_hazard_forward_unit.sv
// -----------------------------------------------------------------------------
// tb_hazard_forward_unit
// Directed stimulus with hand-computed expectations. The driver pushes the
// expected outputs for each step into a queue; an independent monitor pops
// and compares at the falling edge (and shortly after it, for the mid-cycle
// reset step).
// -----------------------------------------------------------------------------
module tb_hazard_forward_unit;

  localparam logic [31:0] RF1  = 32'h1111_1111;
  localparam logic [31:0] RF2  = 32'h2222_2222;
  localparam logic [31:0] EXR  = 32'h0000_0010;
  localparam logic [31:0] MEMR = 32'hDEAD_BEEF;
  localparam logic [31:0] WBD  = 32'h3333_3333;

  logic        clock;
  logic        reset;
  logic        id_valid;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic        id_rs1_used, id_rs2_used, id_reg_write, id_is_load;
  logic [31:0] id_rs1_data, id_rs2_data, ex_result, mem_result, wb_data;
  logic        ex_branch_taken, mem_stall;
  logic [1:0]  fwd_rs1_sel, fwd_rs2_sel;
  logic [31:0] fwd_rs1_data, fwd_rs2_data;
  logic        stall, flush;
`ifdef HAZARD_STATS_EN
  logic [31:0] stall_count, flush_count;
`endif

  typedef struct {
    logic [1:0]  s1;
    logic [1:0]  s2;
    logic [31:0] d1;
    logic [31:0] d2;
    logic        st;
    logic        fl;
    logic        cnt0;
    string       tag;
  } exp_t;

  exp_t exp_q[$];
  int   checks;
  int   errors;

  hazard_forward_unit #(.CORE(0), .DATA_WIDTH(32)) dut (
    .clock           (clock),
    .reset           (reset),
    .id_valid        (id_valid),
    .id_rs1          (id_rs1),
    .id_rs2          (id_rs2),
    .id_rs1_used     (id_rs1_used),
    .id_rs2_used     (id_rs2_used),
    .id_rd           (id_rd),
    .id_reg_write    (id_reg_write),
    .id_is_load      (id_is_load),
    .id_rs1_data     (id_rs1_data),
    .id_rs2_data     (id_rs2_data),
    .ex_result       (ex_result),
    .mem_result      (mem_result),
    .wb_data         (wb_data),
    .ex_branch_taken (ex_branch_taken),
    .mem_stall       (mem_stall),
    .fwd_rs1_sel     (fwd_rs1_sel),
    .fwd_rs2_sel     (fwd_rs2_sel),
    .fwd_rs1_data    (fwd_rs1_data),
    .fwd_rs2_data    (fwd_rs2_data),
    .stall           (stall),
    .flush           (flush)
`ifdef HAZARD_STATS_EN
    ,
    .stall_count     (stall_count),
    .flush_count     (flush_count)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic cmp(input string tag, input string what,
                     input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s.%s: got 0x%08h expected 0x%08h", tag, what, act, req);
    end
  endtask

  task automatic check_pop();
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      cmp(e.tag, "rs1_sel",  {30'd0, fwd_rs1_sel}, {30'd0, e.s1});
      cmp(e.tag, "rs2_sel",  {30'd0, fwd_rs2_sel}, {30'd0, e.s2});
      cmp(e.tag, "rs1_data", fwd_rs1_data, e.d1);
      cmp(e.tag, "rs2_data", fwd_rs2_data, e.d2);
      cmp(e.tag, "stall",    {31'd0, stall}, {31'd0, e.st});
      cmp(e.tag, "flush",    {31'd0, flush}, {31'd0, e.fl});
`ifdef HAZARD_STATS_EN
      if (e.cnt0) begin
        cmp(e.tag, "stall_count", stall_count, 32'd0);
        cmp(e.tag, "flush_count", flush_count, 32'd0);
      end
`endif
    end
  endtask

  // Monitor: compare whatever the driver has queued for this cycle.
  always @(negedge clock) begin
    check_pop();
    #3;
    check_pop();
  end

  task automatic push(input string tag, input logic [1:0] s1, input logic [1:0] s2,
                      input logic [31:0] d1, input logic [31:0] d2,
                      input logic st, input logic fl, input logic cnt0);
    exp_t e;
    e.tag = tag; e.s1 = s1; e.s2 = s2; e.d1 = d1; e.d2 = d2;
    e.st = st; e.fl = fl; e.cnt0 = cnt0;
    exp_q.push_back(e);
  endtask

  // One decode cycle: drive just after the rising edge, queue the expectation.
  task automatic step(input string tag,
                      input logic [4:0] rs1, input logic u1,
                      input logic [4:0] rs2, input logic u2,
                      input logic [4:0] rd, input logic rw, input logic ld,
                      input logic br, input logic ms,
                      input logic [1:0] s1, input logic [1:0] s2,
                      input logic [31:0] d1, input logic [31:0] d2,
                      input logic st, input logic fl);
    @(posedge clock);
    #1;
    id_valid = 1'b1;
    id_rs1 = rs1; id_rs1_used = u1;
    id_rs2 = rs2; id_rs2_used = u2;
    id_rd = rd; id_reg_write = rw; id_is_load = ld;
    ex_branch_taken = br; mem_stall = ms;
    push(tag, s1, s2, d1, d2, st, fl, 1'b0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b0;
    id_valid = 1'b0; id_rs1 = 5'd0; id_rs2 = 5'd0; id_rd = 5'd0;
    id_rs1_used = 1'b0; id_rs2_used = 1'b0; id_reg_write = 1'b0; id_is_load = 1'b0;
    id_rs1_data = RF1; id_rs2_data = RF2;
    ex_result = EXR; mem_result = MEMR; wb_data = WBD;
    ex_branch_taken = 1'b0; mem_stall = 1'b0;

    // Reset state.
    @(posedge clock);
    #1;
    push("reset", 2'd0, 2'd0, RF1, RF2, 1'b0, 1'b0, 1'b1);
    @(negedge clock);
    #4;
    reset = 1'b1;

    //            tag        rs1  u    rs2  u    rd   rw   ld   br   ms   s1    s2    d1    d2    st   fl
    step("addi_x5",  5'd0,1'b0,5'd0,1'b0,5'd5,1'b1,1'b0,1'b0,1'b0,2'd0,2'd0,RF1, RF2, 1'b0,1'b0);
    step("fwd_ex",   5'd5,1'b1,5'd0,1'b1,5'd0,1'b0,1'b0,1'b0,1'b0,2'd1,2'd0,EXR, RF2, 1'b0,1'b0);
    step("lw_x6",    5'd0,1'b0,5'd0,1'b0,5'd6,1'b1,1'b1,1'b0,1'b0,2'd0,2'd0,RF1, RF2, 1'b0,1'b0);
    step("load_use", 5'd5,1'b1,5'd6,1'b1,5'd0,1'b0,1'b0,1'b0,1'b0,2'd3,2'd1,WBD, EXR, 1'b1,1'b0);
    step("lu_mem",   5'd5,1'b1,5'd6,1'b1,5'd7,1'b1,1'b0,1'b0,1'b0,2'd0,2'd2,RF1, MEMR,1'b0,1'b0);
    step("w_x8",     5'd0,1'b0,5'd0,1'b0,5'd8,1'b1,1'b0,1'b0,1'b0,2'd0,2'd0,RF1, RF2, 1'b0,1'b0);
    step("w_x7",     5'd0,1'b0,5'd0,1'b0,5'd7,1'b1,1'b0,1'b0,1'b0,2'd0,2'd0,RF1, RF2, 1'b0,1'b0);
    step("ex_wins",  5'd7,1'b1,5'd0,1'b1,5'd0,1'b1,1'b0,1'b0,1'b0,2'd1,2'd0,EXR, RF2, 1'b0,1'b0);
    @(posedge clock);
    #1;
    id_rs1_data = 32'd0;
    // x0 read while EX holds an rd=0 record; x8 comes from WB.
    id_valid = 1'b1; id_rs1 = 5'd0; id_rs1_used = 1'b1; id_rs2 = 5'd8; id_rs2_used = 1'b1;
    id_rd = 5'd9; id_reg_write = 1'b1; id_is_load = 1'b1;
    ex_branch_taken = 1'b0; mem_stall = 1'b0;
    push("x0_wb", 2'd0, 2'd3, 32'd0, WBD, 1'b0, 1'b0, 1'b0);
    @(negedge clock);
    #4;
    id_rs1_data = RF1;
    step("lu_branch",5'd9,1'b1,5'd0,1'b0,5'd0,1'b0,1'b0,1'b1,1'b0,2'd1,2'd0,EXR, RF2, 1'b0,1'b1);
    step("post_br",  5'd9,1'b1,5'd0,1'b0,5'd1,1'b1,1'b0,1'b0,1'b0,2'd2,2'd0,MEMR,RF2, 1'b0,1'b0);
    step("w_x2",     5'd0,1'b0,5'd0,1'b0,5'd2,1'b1,1'b0,1'b0,1'b0,2'd0,2'd0,RF1, RF2, 1'b0,1'b0);
    step("w_x3",     5'd0,1'b0,5'd0,1'b0,5'd3,1'b1,1'b0,1'b0,1'b0,2'd0,2'd0,RF1, RF2, 1'b0,1'b0);
    for (int i = 0; i < 3; i++) begin
      step("mstall",  5'd3,1'b1,5'd1,1'b1,5'd4,1'b1,1'b0,1'b1,1'b1,2'd1,2'd3,EXR, WBD, 1'b1,1'b0);
    end
    step("ms_done",  5'd3,1'b1,5'd1,1'b1,5'd4,1'b1,1'b0,1'b0,1'b0,2'd1,2'd3,EXR, WBD, 1'b0,1'b0);
    step("advance",  5'd3,1'b1,5'd1,1'b1,5'd10,1'b1,1'b1,1'b0,1'b0,2'd2,2'd0,MEMR,RF2, 1'b0,1'b0);
    step("lu2",      5'd10,1'b1,5'd4,1'b1,5'd0,1'b0,1'b0,1'b0,1'b0,2'd1,2'd2,EXR, MEMR,1'b1,1'b0);

    // Reset in the middle of the load-use stall cycle.
    @(negedge clock);
    #1;
    reset = 1'b0;
    push("mid_reset", 2'd0, 2'd0, RF1, RF2, 1'b0, 1'b0, 1'b1);
    @(posedge clock);
    #1;
    reset = 1'b1;
    push("post_reset", 2'd0, 2'd0, RF1, RF2, 1'b0, 1'b0, 1'b0);
    step("after_rst",5'd10,1'b1,5'd4,1'b1,5'd0,1'b0,1'b0,1'b0,1'b0,2'd0,2'd0,RF1, RF2, 1'b0,1'b0);

    repeat (3) @(posedge clock);
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Absolute time bound so the run always ends.
  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
